// File: rtl/invader_march_ctrl_pkg.sv
// Shared types and constants for the alien formation march controller.
package invader_march_ctrl_pkg;

  localparam int unsigned ALIVE_W = 6;
  localparam int unsigned LVL_W   = 3;

  localparam int unsigned THR_L0 = 40;
  localparam int unsigned THR_L1 = 25;
  localparam int unsigned THR_L2 = 12;
  localparam int unsigned THR_L3 = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARCH   = 2'd1,
    ST_DESCEND = 2'd2,
    ST_LANDED  = 2'd3
  } state_e;

  // Fewer aliens left means a faster march.
  function automatic logic [LVL_W-1:0] lvl_from_alive(input logic [ALIVE_W-1:0] alive);
    if (alive >= ALIVE_W'(THR_L0))      return LVL_W'(0);
    else if (alive >= ALIVE_W'(THR_L1)) return LVL_W'(1);
    else if (alive >= ALIVE_W'(THR_L2)) return LVL_W'(2);
    else if (alive >= ALIVE_W'(THR_L3)) return LVL_W'(3);
    else                                return LVL_W'(4);
  endfunction

endpackage

// File: rtl/invader_march_ctrl_speed_tick_gen.sv
// Movement tick generator: period is BASE_PERIOD shifted down by the speed level.
module invader_march_ctrl_speed_tick_gen
  import invader_march_ctrl_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic             en,
  input  logic             clr,
  input  logic [LVL_W-1:0] lvl,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_c;

  assign last_c = (CNT_W'(BASE_PERIOD) >> lvl) - CNT_W'(1);
  // >= so a speed-up that shortens the period below the current count fires at once
  assign tick   = en && (cnt_q >= last_c);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/invader_march_ctrl.sv
// Alien formation march sequencer: speed selection, wall bounce/descent, landing detect.
module invader_march_ctrl
  import invader_march_ctrl_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 50_000_000,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned POS_W       = 10,
  parameter int unsigned X_START     = 64,
  parameter int unsigned Y_START     = 32,
  parameter int unsigned X_MIN       = 8,
  parameter int unsigned X_MAX       = 400,
  parameter int unsigned STEP_X      = 8,
  parameter int unsigned STEP_Y      = 16,
  parameter int unsigned Y_LAND      = 416
) (
  input  logic               CLK,
  input  logic               Rst,
  input  logic               start,
  input  logic               pause,
  input  logic [ALIVE_W-1:0] alive_cnt,
  output logic [POS_W-1:0]   frm_x,
  output logic [POS_W-1:0]   frm_y,
  output logic               dir,
  output logic [LVL_W-1:0]   speed_lvl,
  output logic               step_pulse,
  output logic               wave_clr,
  output logic               landed
);

  localparam int unsigned SUM_W = POS_W + 1;

  state_e           state_q, state_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             dir_q, dir_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             step_q, step_d, wclr_q, wclr_d, landed_q, landed_d;
  logic             marching_c, tick_en_c, tick_c, clr_c, at_wall_c;
  logic [SUM_W-1:0] sum_x_c, sum_y_c;

  assign marching_c = (state_q == ST_MARCH) || (state_q == ST_DESCEND);
  assign tick_en_c  = marching_c && !pause;

  invader_march_ctrl_speed_tick_gen #(
    .BASE_PERIOD(BASE_PERIOD),
    .CNT_W      (CNT_W)
  ) u_tick (
    .CLK (CLK),
    .Rst (Rst),
    .en  (tick_en_c),
    .clr (clr_c),
    .lvl (lvl_q),
    .tick(tick_c)
  );

  // One extra bit keeps the wall and landing compares from wrapping.
  assign sum_x_c   = {1'b0, x_q} + SUM_W'(STEP_X);
  assign sum_y_c   = {1'b0, y_q} + SUM_W'(STEP_Y);
  assign at_wall_c = dir_q ? (sum_x_c > SUM_W'(X_MAX))
                           : ({1'b0, x_q} < SUM_W'(X_MIN + STEP_X));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    lvl_d   = lvl_from_alive(alive_cnt);
    step_d  = 1'b0;
    wclr_d  = 1'b0;
    clr_c   = 1'b0;
    if (!pause) begin
      case (state_q)
        ST_IDLE, ST_LANDED: begin
          if (start) begin
            x_d     = POS_W'(X_START);
            y_d     = POS_W'(Y_START);
            dir_d   = 1'b1;
            clr_c   = 1'b1;
            state_d = ST_MARCH;
          end
        end
        ST_MARCH: begin
          if (alive_cnt == '0) begin
            wclr_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (tick_c) begin
            if (at_wall_c) begin
              state_d = ST_DESCEND;
            end else begin
              x_d    = dir_q ? sum_x_c[POS_W-1:0] : x_q - POS_W'(STEP_X);
              step_d = 1'b1;
            end
          end
        end
        ST_DESCEND: begin
          if (alive_cnt == '0) begin
            wclr_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (tick_c) begin
            y_d     = sum_y_c[POS_W-1:0];
            dir_d   = !dir_q;
            step_d  = 1'b1;
            state_d = (sum_y_c >= SUM_W'(Y_LAND)) ? ST_LANDED : ST_MARCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    landed_d = (state_d == ST_LANDED);
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      x_q      <= POS_W'(X_START);
      y_q      <= POS_W'(Y_START);
      dir_q    <= 1'b1;
      lvl_q    <= '0;
      step_q   <= 1'b0;
      wclr_q   <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      lvl_q    <= lvl_d;
      step_q   <= step_d;
      wclr_q   <= wclr_d;
      landed_q <= landed_d;
    end
  end

  assign frm_x      = x_q;
  assign frm_y      = y_q;
  assign dir        = dir_q;
  assign speed_lvl  = lvl_q;
  assign step_pulse = step_q;
  assign wave_clr   = wclr_q;
  assign landed     = landed_q;

endmodule
